ct_key_verifier: RTL

Parametrised, constant-time successor to the team's combinational secret comparator. It stores a secret key and compares each submitted candidate chunk-by-chunk over a fixed number of cycles, with no early exit and no data-dependent timing. Consecutive failures are counted, and a lockout window follows repeated failures. It sits between the host-facing unlock request path and the secure-state controller.

---
 rtl/ct_key_verifier.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ct_key_verifier.sv
// Constant-time secret key verifier: chunk-serial compare with no early exit,
// consecutive-failure counting and a fixed-length lockout window.
module ct_key_verifier #(
  parameter  int KEY_WIDTH      = 64,
  parameter  int CHUNK_WIDTH    = 8,
  parameter  int MAX_FAILS      = 3,
  parameter  int LOCKOUT_CYCLES = 256,
  localparam int FCW            = $clog2(MAX_FAILS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_load,
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [KEY_WIDTH-1:0] req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_match,
  output logic                 locked,
  output logic [FCW-1:0]       fail_count
);

  localparam int NCHUNK = KEY_WIDTH / CHUNK_WIDTH;
  localparam int IDXW   = $clog2(NCHUNK + 1);
  localparam int LCW    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_RESP, S_LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic                   key_valid_q, key_valid_d;
  logic [KEY_WIDTH-1:0]   cand_q, cand_d;
  logic [CHUNK_WIDTH-1:0] acc_q, acc_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [LCW-1:0]         lock_cnt_q, lock_cnt_d;
  logic [FCW-1:0]         fail_q, fail_d;
  logic                   resp_match_q, resp_match_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   locked_q, locked_d;
  logic                   ready_q, ready_d;

  logic [KEY_WIDTH-1:0]   diff_s;
  logic [CHUNK_WIDTH-1:0] diff_chunk_s;

  assign req_ready  = ready_q & ~key_load;
  assign resp_valid = resp_valid_q;
  assign resp_match = resp_match_q;
  assign locked     = locked_q;
  assign fail_count = fail_q;

  assign diff_s = key_q ^ cand_q;

  // Full mux over every chunk so the selection path is identical for each index
  always_comb begin
    diff_chunk_s = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        diff_chunk_s = diff_s[i*CHUNK_WIDTH +: CHUNK_WIDTH];
      end else begin
        diff_chunk_s = diff_chunk_s;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      cand_q       <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      lock_cnt_q   <= '0;
      fail_q       <= '0;
      resp_match_q <= 1'b0;
      resp_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      cand_q       <= cand_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      lock_cnt_q   <= lock_cnt_d;
      fail_q       <= fail_d;
      resp_match_q <= resp_match_d;
      resp_valid_q <= resp_valid_d;
      locked_q     <= locked_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    cand_d       = cand_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    lock_cnt_d   = lock_cnt_q;
    fail_d       = fail_q;
    resp_match_d = resp_match_q;
    case (state_q)
      S_IDLE: begin
        if (key_load) begin
          key_d       = key_in;
          key_valid_d = 1'b1;
        end else if (req_valid && req_ready) begin
          cand_d  = req_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_COMPARE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPARE: begin
        // idx reaching NCHUNK means every chunk has been folded into acc
        if (idx_q == IDXW'(NCHUNK)) begin
          state_d      = S_RESP;
          resp_match_d = (acc_q == '0) && key_valid_q;
          if ((acc_q == '0) && key_valid_q) begin
            fail_d = '0;
          end else if (fail_q != FCW'(MAX_FAILS)) begin
            fail_d = fail_q + 1'b1;
          end else begin
            fail_d = fail_q;
          end
        end else begin
          acc_d = acc_q | diff_chunk_s;
          idx_d = idx_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_match_d = 1'b0;
          if (fail_q == FCW'(MAX_FAILS)) begin
            state_d    = S_LOCKED;
            lock_cnt_d = LCW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      S_LOCKED: begin
        if (lock_cnt_q == '0) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered status outputs follow the state being entered
  always_comb begin
    ready_d      = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    locked_d     = (state_d == S_LOCKED);
  end

endmodule
